// File: rtl/hand_bank.sv
// -----------------------------------------------------------------------------
// hand_bank
//   Card store for NUM_HANDS hands of up to CARDS_PER_HAND cards each. Dealt
//   cards arrive over a valid/ready handshake. Each hand keeps a fill count and
//   a running baccarat score (sum of card values mod 10).
//
//   Optional feature macro: HAND_NATURAL_EN
//     defined   - natural[h] latches when a hand's second card brings its score
//                 to 8 or 9, and that hand then refuses further cards.
//     undefined - natural is tied to zero and hands fill to CARDS_PER_HAND.
//
// Ports
//   slow_clock  sole clock, rising edge
//   reset       asynchronous active-high clear of all state
//   clear       synchronous clear of every hand (new round), beats any deal
//   new_card    card code 1=A, 2..10, 11=J, 12=Q, 13=K
//   deal_valid  new_card is offered to hand deal_hand
//   deal_hand   target hand index
//   deal_ready  combinational: target hand can take new_card this cycle
//   cards       slot s of hand h at [(h*CARDS_PER_HAND+s)*4 +: 4], empty slot = 0
//   count       cards held by hand h at [h*CW +: CW]
//   score       running score of hand h at [h*4 +: 4], 0..9
//   hand_full   count == CARDS_PER_HAND, one bit per hand
//   err         one-cycle pulse the cycle after a refused offer
//   natural     per-hand natural flag (zero unless HAND_NATURAL_EN)
// -----------------------------------------------------------------------------
module hand_bank #(
   parameter int unsigned NUM_HANDS      = 2,
   parameter int unsigned CARDS_PER_HAND = 3,
   localparam int unsigned HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
   localparam int unsigned CW = $clog2(CARDS_PER_HAND + 1)
) (
   input  logic                                  slow_clock,
   input  logic                                  reset,
   input  logic                                  clear,
   input  logic [3:0]                            new_card,
   input  logic                                  deal_valid,
   input  logic [HW-1:0]                         deal_hand,
   output logic                                  deal_ready,
   output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards,
   output logic [NUM_HANDS*CW-1:0]               count,
   output logic [NUM_HANDS*4-1:0]                score,
   output logic [NUM_HANDS-1:0]                  hand_full,
   output logic                                  err,
   output logic [NUM_HANDS-1:0]                  natural
);

   localparam logic [CW-1:0] FullCnt = CW'(CARDS_PER_HAND);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [3:0]    cards_q [NUM_HANDS][CARDS_PER_HAND];
   logic [3:0]    cards_d [NUM_HANDS][CARDS_PER_HAND];
   logic [CW-1:0] count_q [NUM_HANDS];
   logic [CW-1:0] count_d [NUM_HANDS];
   logic [3:0]    score_q [NUM_HANDS];
   logic [3:0]    score_d [NUM_HANDS];
   logic          err_q;
   logic          err_d;
`ifdef HAND_NATURAL_EN
   logic [NUM_HANDS-1:0] natural_q;
   logic [NUM_HANDS-1:0] natural_d;
`endif

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   logic [NUM_HANDS-1:0] hand_sel;   // one-hot target; all zero when out of range
   logic [NUM_HANDS-1:0] full_vec;
   logic [NUM_HANDS-1:0] closed_vec; // hands that refuse any further card
   logic                 code_ok;
   logic                 accept;
   logic [3:0]           card_val;
   logic [3:0]           sel_score;
   logic [4:0]           sum;
   logic [3:0]           new_score;

   always_comb begin
      hand_sel = '0;
      full_vec = '0;
      for (int h = 0; h < int'(NUM_HANDS); h++) begin
         hand_sel[h] = (deal_hand == HW'(h));
         full_vec[h] = (count_q[h] == FullCnt);
      end
   end

`ifdef HAND_NATURAL_EN
   assign closed_vec = full_vec | natural_q;
`else
   assign closed_vec = full_vec;
`endif

   assign code_ok    = (new_card != 4'd0) && (new_card <= 4'd13);
   assign deal_ready = !clear && (|hand_sel) && !(|(hand_sel & closed_vec)) && code_ok;
   assign accept     = deal_valid && deal_ready;

   // Face cards and tens count as zero.
   assign card_val = (new_card <= 4'd9) ? new_card : 4'd0;

   always_comb begin
      sel_score = '0;
      for (int h = 0; h < int'(NUM_HANDS); h++) begin
         if (hand_sel[h]) begin
            sel_score = score_q[h];
         end
      end
   end

   // Both operands are at most 9, so one conditional subtract keeps the result in 0..9.
   assign sum       = {1'b0, sel_score} + {1'b0, card_val};
   assign new_score = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      cards_d = cards_q;
      count_d = count_q;
      score_d = score_q;
`ifdef HAND_NATURAL_EN
      natural_d = natural_q;
`endif
      // A refused offer is reported only when clear is not absorbing it.
      err_d = deal_valid && !deal_ready && !clear;

      if (clear) begin
         for (int h = 0; h < int'(NUM_HANDS); h++) begin
            count_d[h] = '0;
            score_d[h] = '0;
            for (int s = 0; s < int'(CARDS_PER_HAND); s++) begin
               cards_d[h][s] = '0;
            end
         end
`ifdef HAND_NATURAL_EN
         natural_d = '0;
`endif
      end else if (accept) begin
         for (int h = 0; h < int'(NUM_HANDS); h++) begin
            if (hand_sel[h]) begin
               count_d[h] = count_q[h] + CW'(1);
               score_d[h] = new_score;
               for (int s = 0; s < int'(CARDS_PER_HAND); s++) begin
                  if (count_q[h] == CW'(s)) begin
                     cards_d[h][s] = new_card;
                  end
               end
`ifdef HAND_NATURAL_EN
               // This accept is the hand's second card.
               if ((count_q[h] == CW'(1)) && (new_score >= 4'd8)) begin
                  natural_d[h] = 1'b1;
               end
`endif
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         for (int h = 0; h < int'(NUM_HANDS); h++) begin
            count_q[h] <= '0;
            score_q[h] <= '0;
            for (int s = 0; s < int'(CARDS_PER_HAND); s++) begin
               cards_q[h][s] <= '0;
            end
         end
         err_q <= 1'b0;
`ifdef HAND_NATURAL_EN
         natural_q <= '0;
`endif
      end else begin
         cards_q <= cards_d;
         count_q <= count_d;
         score_q <= score_d;
         err_q   <= err_d;
`ifdef HAND_NATURAL_EN
         natural_q <= natural_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Flattened outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      cards = '0;
      count = '0;
      score = '0;
      for (int h = 0; h < int'(NUM_HANDS); h++) begin
         count[h*CW +: CW] = count_q[h];
         score[h*4 +: 4]   = score_q[h];
         for (int s = 0; s < int'(CARDS_PER_HAND); s++) begin
            cards[(h*int'(CARDS_PER_HAND) + s)*4 +: 4] = cards_q[h][s];
         end
      end
   end

   assign hand_full = full_vec;
   assign err       = err_q;

`ifdef HAND_NATURAL_EN
   assign natural = natural_q;
`else
   assign natural = '0;
`endif

endmodule
